paicore_link_responder: RTL and testbench

// - Target-side endpoint of one PAICORE parallel link channel (REQ/PDATA/ACK, 4-phase bundled data).
// - Accepts 32-bit link words, pairs them into 64-bit frames and drains them on an AXI-Stream master.
// - Drives BUSY/DONE status back toward the initiator.
// - Used as a chip-side loopback/emulation endpoint and for link bring-up against the transfer datapath.

---
 rtl/paicore_link_responder.sv | 205 ++++++++++++++++++++
 tb/tb_paicore_link_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/paicore_link_responder.sv
// Target-side PAICORE link endpoint: 4-phase REQ/ACK word capture, 64-bit frame pairing, FWFT frame FIFO, AXIS drain.
// Optional ACK-high watchdog enabled by defining PAICORE_RESP_TIMEOUT_EN.
module paicore_link_responder #(
  parameter int LINK_WIDTH      = 32,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH      = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [31:0]                frame_num_max,
  input  logic                       req_i,
  input  logic [LINK_WIDTH-1:0]      pdata_i,
  output logic                       ack_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                frame_cnt,
  output logic                       err_timeout_o,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_ACK} state_e;

  generate
    if (AXIS_DATA_WIDTH != 2 * LINK_WIDTH) begin : g_bad_width
      $error("AXIS_DATA_WIDTH must equal 2*LINK_WIDTH");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  state_e                 state_q, state_d;
  logic                   half_q, half_d;
  logic [LINK_WIDTH-1:0]  hi_q, hi_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;
  logic                   capture, push, pop, full, empty, tlast_new;
  logic                   timeout, rearm;
  logic [AXIS_DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AXIS_DATA_WIDTH:0] rd_word;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], req_i};
  assign req_s  = sync_q[SYNC_STAGES-1];

`ifdef PAICORE_RESP_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;
  logic        rearm_q, rearm_d;

  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (enable && state_q == S_ACK && req_s) begin
      if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                     to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  // After a timeout the link must show req low before another word is taken.
  always_comb begin
    err_d   = err_q | timeout;
    rearm_d = rearm_q;
    if (timeout)     rearm_d = 1'b1;
    else if (!req_s) rearm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
      rearm_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
      rearm_q  <= rearm_d;
    end
  end

  assign rearm         = rearm_q;
  assign err_timeout_o = err_q;
`else
  assign timeout       = 1'b0;
  assign rearm         = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // FSM output process: link acknowledge and word capture decision.
  always_comb begin
    ack_o   = (state_q == S_ACK);
    capture = enable && (state_q == S_IDLE) && req_s && !rearm && (!half_q || !full);
  end

  always_comb begin
    state_d = state_q;
    if (!enable || timeout) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (capture) state_d = S_ACK;
        S_ACK:   if (!req_s)  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign push      = capture && half_q;
  assign pop       = !empty && m_axis_tready;
  assign tlast_new = (frame_num_max != 32'd0) && ((frame_cnt_q + 32'd1) == frame_num_max);

  always_comb begin
    half_d      = half_q;
    hi_d        = hi_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frame_cnt_d = frame_cnt_q;
    if (capture) begin
      half_d = !half_q;
      if (!half_q) hi_d = pdata_i;
    end
    if (push) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (timeout) half_d = 1'b0;
    if (!enable) begin
      half_d      = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      frame_cnt_d = '0;
    end
    busy_d = (count_d >= CW'(FIFO_DEPTH - 2));
    done_d = pop && m_axis_tlast;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= S_IDLE;
      half_q      <= 1'b0;
      hi_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      half_q      <= half_d;
      hi_q        <= hi_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Storage carries {tlast, frame}; no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {tlast_new, hi_q, pdata_i};
  end

  assign rd_word       = mem[rd_ptr_q];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : rd_word[AXIS_DATA_WIDTH-1:0];
  assign m_axis_tlast  = !empty && rd_word[AXIS_DATA_WIDTH];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_paicore_link_responder.sv
// Directed self-checking bench for paicore_link_responder: handshakes, backpressure stall, slow 4-phase, flush, unbounded mode.
module tb_paicore_link_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] frame_num_max = 32'd0;
  logic        req_i = 1'b0;
  logic [31:0] pdata_i = 32'd0;
  logic        m_axis_tready = 1'b0;
  logic        ack_o, busy_o, done_o, err_timeout_o, m_axis_tvalid, m_axis_tlast;
  logic [31:0] frame_cnt;
  logic [63:0] m_axis_tdata;

  int checks = 0;
  int errors = 0;
  logic [64:0] mon_q[$];
  int done_cnt = 0;

  always #5 clk = ~clk;

  paicore_link_responder #(
    .LINK_WIDTH(32), .AXIS_DATA_WIDTH(64), .FIFO_DEPTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_num_max(frame_num_max),
    .req_i(req_i), .pdata_i(pdata_i), .ack_o(ack_o), .busy_o(busy_o), .done_o(done_o),
    .frame_cnt(frame_cnt), .err_timeout_o(err_timeout_o), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  // Inputs change 2ns after posedge, so at negedge a visible valid&ready means a handshake on the next edge.
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) mon_q.push_back({m_axis_tlast, m_axis_tdata});
    if (done_o) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ack(input logic v, input string tag, output int lat);
    lat = 0;
    while (ack_o !== v && lat < 300) begin
      step(1);
      lat++;
    end
    check(tag, ack_o, v);
  endtask

  task automatic hs(input logic [31:0] w, output int lat);
    int l2;
    pdata_i = w;
    req_i   = 1'b1;
    wait_ack(1'b1, "ack_rise", lat);
    req_i = 1'b0;
    wait_ack(1'b0, "ack_fall", l2);
  endtask

  task automatic restart();
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);
  endtask

  function automatic logic [31:0] w2(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  initial begin
    int lat, base, dbase, tl;
    step(3);
    check("rst_ack", ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err_timeout_o, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    rst_n = 1'b1;
    step(2);

    // Basic transfer of two frames, frame_num_max=2
    frame_num_max = 32'd2;
    m_axis_tready = 1'b1;
    enable = 1'b1;
    step(2);
    base  = mon_q.size();
    dbase = done_cnt;
    hs(32'h1111_1111, lat);
    check("ack_latency", lat, 3);
    hs(32'h2222_2222, lat);
    hs(32'h3333_3333, lat);
    hs(32'h4444_4444, lat);
    step(6);
    check("t1_nframes", mon_q.size() - base, 2);
    check("t1_frame0", mon_q[base], {1'b0, 64'h1111_1111_2222_2222});
    check("t1_frame1", mon_q[base+1], {1'b1, 64'h3333_3333_4444_4444});
    check("t1_done_pulses", done_cnt - dbase, 1);
    check("t1_frame_cnt", frame_cnt, 2);

    // Backpressure: fill FIFO, stall, release
    frame_num_max = 32'd0;
    m_axis_tready = 1'b0;
    restart();
    for (int i = 0; i < 33; i++) begin
      hs(w2(i), lat);
      if (i == 25) check("busy_at_13", busy_o, 0);
      if (i == 27) check("busy_at_14", busy_o, 1);
    end
    check("full_frame_cnt", frame_cnt, 16);
    check("full_busy", busy_o, 1);
    pdata_i = w2(33);
    req_i   = 1'b1;
    step(20);
    check("stall_ack", ack_o, 0);
    base = mon_q.size();
    m_axis_tready = 1'b1;
    wait_ack(1'b1, "stall_release", lat);
    req_i = 1'b0;
    wait_ack(1'b0, "stall_ack_fall", lat);
    step(30);
    check("bp_nframes", mon_q.size() - base, 17);
    for (int k = 0; k < 17; k++) check("bp_frame", mon_q[base+k], {1'b0, w2(2*k), w2(2*k+1)});
    check("bp_busy_clear", busy_o, 0);

    // Slow 4-phase: req high 50 clk per pulse
    restart();
    base = mon_q.size();
    for (int p = 0; p < 4; p++) begin
      pdata_i = 32'h5A5A_0000 + 32'(p);
      req_i   = 1'b1;
      step(50);
      check("slow_ack_hi", ack_o, 1);
      req_i = 1'b0;
      step(50);
      check("slow_ack_lo", ack_o, 0);
    end
    check("slow_frame_cnt", frame_cnt, 2);
    check("slow_nframes", mon_q.size() - base, 2);
    check("slow_frame1", mon_q[base+1], {1'b0, 64'h5A5A_0002_5A5A_0003});

    // Disable mid-handshake with half word held and 3 frames queued
    m_axis_tready = 1'b0;
    restart();
    for (int i = 0; i < 6; i++) hs(32'hD000_0000 + 32'(i), lat);
    pdata_i = 32'hD000_0006;
    req_i   = 1'b1;
    wait_ack(1'b1, "dis_ack_rise", lat);
    check("dis_pre_cnt", frame_cnt, 3);
    check("dis_pre_tvalid", m_axis_tvalid, 1);
    enable = 1'b0;
    step(1);
    check("dis_ack", ack_o, 0);
    check("dis_tvalid", m_axis_tvalid, 0);
    check("dis_frame_cnt", frame_cnt, 0);
    enable = 1'b1;
    wait_ack(1'b1, "recapture", lat);
    check("recap_frame_cnt", frame_cnt, 0);
    req_i = 1'b0;
    wait_ack(1'b0, "recap_ack_fall", lat);
    base = mon_q.size();
    m_axis_tready = 1'b1;
    hs(32'hBBBB_BBBB, lat);
    step(3);
    check("recap_frame", mon_q[base], {1'b0, 64'hD000_0006_BBBB_BBBB});

    // Unbounded: frame_num_max=0, ten frames
    frame_num_max = 32'd0;
    restart();
    base  = mon_q.size();
    dbase = done_cnt;
    for (int i = 0; i < 20; i++) hs(32'hE000_0000 + 32'(i), lat);
    step(5);
    tl = 0;
    for (int k = base; k < mon_q.size(); k++) if (mon_q[k][64]) tl++;
    check("nomax_nframes", mon_q.size() - base, 10);
    check("nomax_tlast", tl, 0);
    check("nomax_done", done_cnt - dbase, 0);
    check("nomax_frame_cnt", frame_cnt, 10);

`ifdef PAICORE_RESP_TIMEOUT_EN
    restart();
    pdata_i = 32'hC0FF_EE00;
    req_i   = 1'b1;
    wait_ack(1'b1, "to_ack_rise", lat);
    lat = 0;
    while (ack_o === 1'b1 && lat < 100) begin
      step(1);
      lat++;
    end
    check("to_cycles", lat, 8);
    check("to_err", err_timeout_o, 1);
    step(20);
    check("to_no_recapture", ack_o, 0);
    req_i = 1'b0;
    step(4);
    hs(32'h0000_0001, lat);
    hs(32'h0000_0002, lat);
    check("to_half_discarded", frame_cnt, 1);
    check("to_err_sticky", err_timeout_o, 1);
`else
    check("no_timeout_err", err_timeout_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
